serial_adder_sub: RTL
=====================

Name: serial_adder_sub

Overview:
- Parametrised multi-cycle adder/subtractor built around a DIGIT-bit ripple slice (generalised full adder) reused over WIDTH/DIGIT clock cycles.
- Trades latency for area in datapaths that do not need a single-cycle WIDTH-bit adder.
- Adds a start/busy/done handshake, a subtract mode, a carry/borrow input and signed-overflow detection.

Parameters:
- WIDTH, 16, operand and result width in bits; must be at least 2.
- DIGIT, 1, bits processed per clock cycle; must divide WIDTH exactly.
- STEPS (localparam), WIDTH/DIGIT, number of processing cycles.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only when busy=0
- A  input  WIDTH  operand A, sampled with start
- B  input  WIDTH  operand B, sampled with start
- Cin  input  1  carry-in (Sub=0) or borrow-in (Sub=1), sampled with start
- Sub  input  1  0: A+B+Cin; 1: A-B-Cin, sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result registers update
- Sum  output  WIDTH  result, held between operations
- Cout  output  1  final carry out of the MSB; for Sub=1, 1 means no borrow
- Overflow  output  1  two's-complement overflow of the last result

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset value: all state and outputs cleared (state=IDLE, busy=0, done=0, Sum=0, Cout=0, Overflow=0).
- Reset mid-operation: the operation is abandoned immediately; no done pulse follows.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Accept rule: start=1 at a rising edge while in IDLE or DONE, i.e. busy=0.
- On acceptance:
  - Latch A into the a_shift register.
  - Latch B, or ~B when Sub=1, into the b_shift register.
  - Set carry = Cin when Sub=0, and ~Cin when Sub=1.
  - Clear the step counter and go to RUN.
- start while busy=1 is ignored; operands changing during RUN have no effect.
- RUN, each edge:
  - Add the DIGIT LSBs of a_shift and b_shift with carry.
  - Shift both registers right by DIGIT.
  - Shift the DIGIT result bits into the top of an internal result shift register.
  - Update carry and increment the counter.
- Completion, on the STEPS-th RUN edge:
  - Sum <= completed result.
  - Cout <= carry out of bit WIDTH-1.
  - Overflow <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Go to DONE.
- Latency: with start sampled at edge 0, done is high in the cycle after edge STEPS (WIDTH=16, DIGIT=1: edge 16).
- Sum, Cout and Overflow change only on the completion edge; they hold their values through RUN of the next operation and through IDLE.
- From DONE: with start=1 the block goes back to RUN (back-to-back operation, no idle gap); otherwise it goes to IDLE.
- Arithmetic: result is modulo 2^WIDTH; Cout and Overflow are computed as above for both modes.
- Counter width: clog2(STEPS) bits, minimum 1; no wrap-around beyond STEPS.

Test Plan:
1. WIDTH=8, DIGIT=1; A=0x5A, B=0x33, Cin=0, Sub=0, start at edge 0 -> done high after edge 8 only; Sum=0x8D, Cout=0, Overflow=1; busy high for exactly 8 cycles.
2. WIDTH=8, DIGIT=1; A=0xFF, B=0x01, Cin=1, Sub=0 -> Sum=0x01, Cout=1, Overflow=0. Then A=0x10, B=0x20, Cin=0, Sub=1 -> Sum=0xF0, Cout=0, Overflow=0.
3. WIDTH=8, DIGIT=1; A=0x80, B=0x01, Cin=0, Sub=1 -> Sum=0x7F, Cout=1, Overflow=1. Then A=0x05, B=0x03, Cin=1, Sub=1 -> Sum=0x01, Cout=1, Overflow=0.
4. Handshake:
   - Start A=0x01, B=0x01.
   - At edge 3, pulse start with A=0xFF, B=0xFF -> ignored; result Sum=0x02.
   - Hold start=1 with new operands A=0x02, B=0x02 during the DONE cycle -> accepted; Sum=0x04 after another 8 RUN edges.
   - Sum holds 0x02 throughout the second RUN.
5. Reset mid-run:
   - Start A=0x5A, B=0x33; assert reset between edges 3 and 4 -> busy=0, done=0, Sum=0 immediately, asynchronously.
   - No done pulse follows.
   - After release, A=0x22, B=0x11 -> Sum=0x33.
6. WIDTH=8, DIGIT=4 instance; A=0x5A, B=0x33, Sub=0 -> done after edge 2, Sum=0x8D, Overflow=1. WIDTH=16, DIGIT=1 with A=0xFFFF, B=0x0001 -> Sum=0x0000, Cout=1 at edge 16.

Source files
------------

// File: rtl/serial_adder_sub.sv
// Multi-cycle adder/subtractor: a DIGIT-bit ripple slice is reused over WIDTH/DIGIT cycles.
// Start/busy/done handshake, subtract mode, carry/borrow in, and signed-overflow detection.
module serial_adder_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] a_d, b_d, res_d;
    logic             carry_d, ovf_d;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        carry_d = slice[DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters at the top; after STEPS shifts the first digit sits at bit 0.
        res_d   = (res_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
        // Carry into the slice MSB recovered as a ^ b ^ sum of that bit.
        ovf_d   = (a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1]) ^ slice[DIGIT];
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    if (cnt_q == CW'(STEPS - 1)) begin
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= Sub ? ~B : B;
                        carry_q <= Cin ^ Sub;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Sum      = sum_q;
    assign Cout     = cout_q;
    assign Overflow = ovf_q;

endmodule
